// File: rtl/quad_velocity_pkg.sv
// Shared constants, register map and FSM states
// for the four-channel quadrature velocity block.
package quad_pkg;

    localparam int NUM_CH = 4;

    localparam logic [2:0] VEL0   = 3'd0;
    localparam logic [2:0] VEL1   = 3'd1;
    localparam logic [2:0] VEL2   = 3'd2;
    localparam logic [2:0] VEL3   = 3'd3;
    localparam logic [2:0] PERIOD = 3'd4;
    localparam logic [2:0] STATUS = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } stateT;

    // Position change between samples; the 16-bit
    // wrap makes 0xFFFF->0x0000 crossings come out right.
    function automatic logic [15:0] wrapDelta(
        input logic [15:0] snap,
        input logic [15:0] prev
    );
        return snap - prev;
    endfunction

endpackage

// File: rtl/quad_velocity_if.sv
// Register bus between a host and quad_velocity.
// Reads are combinational, writes take effect on Clk.
interface quad_velocity_if;

    logic [2:0]  Addr;
    logic [15:0] DataWr;
    logic [15:0] DataRd;
    logic        En;
    logic        Rd;
    logic        Wr;

    modport master (
        output Addr, DataWr, En, Rd, Wr,
        input  DataRd
    );

    modport slave (
        input  Addr, DataWr, En, Rd, Wr,
        output DataRd
    );

endinterface

// File: rtl/quad_velocity_timebase.sv
// Prescaler plus period counter; SampleReq pulses
// for one Clk when the period counter hits Period-1.
module quad_timebase #(
    parameter int PRESCALE = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Period,
    input  logic        Restart,
    output logic        SampleReq
);

    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] presc;
    logic [15:0]   cnt;
    logic          tick;
    logic          atEnd;
    logic          running;

    assign tick      = &presc;
    assign running   = Period != 16'd0;
    assign atEnd     = cnt == (Period - 16'd1);
    assign SampleReq = tick && running && atEnd && !Restart;

    // Free-running prescaler and tick-driven period counter
    always_ff @(posedge Clk) begin
        if (Reset || Restart) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= presc + PW'(1);
            if (tick && running)
                cnt <= atEnd ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/quad_velocity.sv
// Samples four position counters each period and
// publishes coherent signed velocities over a bus.
module quad_velocity
    import quad_pkg::*;
#(
    parameter int PRESCALE   = 64,
    parameter int PERIOD_RST = 15625
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Count0,
    input  logic [15:0] Count1,
    input  logic [15:0] Count2,
    input  logic [15:0] Count3,
    quad_velocity_if.slave Bus,
    output logic        SampleStrobe
);

    stateT state;
    stateT nextState;

    logic [15:0] period;
    logic [NUM_CH-1:0][15:0] countIn;
    logic [NUM_CH-1:0][15:0] snap;
    logic [NUM_CH-1:0][15:0] prev;
    logic [NUM_CH-1:0][15:0] shadow;
    logic [NUM_CH-1:0][15:0] vel;
    logic [1:0]  ch;
    logic        newFlag;
    logic        primed;
    logic        restart;
    logic        statusRd;
    logic        sampleReq;
    logic [15:0] delta;
    logic [15:0] rdData;

    assign countIn  = {Count3, Count2, Count1, Count0};
    assign restart  = Bus.Wr && Bus.En && (Bus.Addr == PERIOD);
    assign statusRd = Bus.Rd && Bus.En && (Bus.Addr == STATUS);
    assign delta    = wrapDelta(snap[ch], prev[ch]);

    quad_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .Clk       (Clk),
        .Reset     (Reset),
        .Period    (period),
        .Restart   (restart),
        .SampleReq (sampleReq)
    );

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next state: one CALC cycle per channel, then COMMIT
    always_comb begin
        nextState    = state;
        SampleStrobe = 1'b0;
        unique case (state)
            IDLE:
                if (sampleReq)
                    nextState = CALC;
            CALC:
                if (ch == 2'd3)
                    nextState = COMMIT;
            COMMIT: begin
                nextState    = IDLE;
                SampleStrobe = 1'b1;
            end
            default:
                nextState = IDLE;
        endcase
    end

    // Period register, snapshot, delta pipeline, status
    always_ff @(posedge Clk) begin
        if (Reset) begin
            period  <= 16'(PERIOD_RST);
            snap    <= '0;
            prev    <= '0;
            shadow  <= '0;
            vel     <= '0;
            ch      <= '0;
            newFlag <= 1'b0;
            primed  <= 1'b0;
        end else begin
            if (restart)
                period <= Bus.DataWr;
            if (state == IDLE && sampleReq) begin
                snap <= countIn;
                ch   <= '0;
            end
            if (state == CALC) begin
                shadow[ch] <= primed ? delta : 16'd0;
                prev[ch]   <= snap[ch];
                ch         <= ch + 2'd1;
            end
            if (state == COMMIT) begin
                vel     <= shadow;
                primed  <= 1'b1;
                newFlag <= 1'b1;
            end else if (statusRd) begin
                newFlag <= 1'b0;
            end
        end
    end

    // Zero-latency register read mux
    always_comb begin
        rdData = '0;
        case (Bus.Addr)
            VEL0, VEL1, VEL2, VEL3:
                rdData = vel[Bus.Addr[1:0]];
            PERIOD:
                rdData = period;
            STATUS:
                rdData = {14'd0, primed, newFlag};
            default:
                rdData = '0;
        endcase
    end

    assign Bus.DataRd = rdData;

endmodule

// File: tb/tb_quad_velocity.sv
// Self-checking bench for quad_velocity: vector table
// with a scoreboard queue plus multi-cycle corner cases.
module tb_quad_velocity;
    import quad_pkg::*;

    localparam int PRESCALE   = 8;
    localparam int PERIOD_RST = 15625;

    typedef logic [3:0][15:0] quadT;

    typedef struct packed {
        quadT cnt;
        quadT exp;
    } vecT;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Count0, Count1, Count2, Count3;
    logic        SampleStrobe;

    quad_velocity_if bus ();

    quad_velocity #(
        .PRESCALE   (PRESCALE),
        .PERIOD_RST (PERIOD_RST)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Count0       (Count0),
        .Count1       (Count1),
        .Count2       (Count2),
        .Count3       (Count3),
        .Bus          (bus),
        .SampleStrobe (SampleStrobe)
    );

    always #5 Clk = ~Clk;

    int   nVec = 0;
    int   nMis = 0;
    vecT  vecs[4];
    quadT expQ[$];

    task automatic check(input string name,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h want %h",
                     name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic rdReg(input logic [2:0] a,
                         output logic [15:0] d);
        bus.Addr = a;
        #1;
        d = bus.DataRd;
    endtask

    task automatic busWrite(input logic [2:0] a,
                            input logic [15:0] d);
        bus.Addr   = a;
        bus.DataWr = d;
        bus.Wr     = 1'b1;
        step();
        bus.Wr     = 1'b0;
    endtask

    task automatic clearNew();
        bus.Addr = STATUS;
        bus.Rd   = 1'b1;
        step();
        bus.Rd   = 1'b0;
    endtask

    task automatic setCounts(input quadT c);
        Count0 = c[0];
        Count1 = c[1];
        Count2 = c[2];
        Count3 = c[3];
    endtask

    task automatic checkVels(input string name,
                             input quadT e);
        logic [15:0] d;
        for (int k = 0; k < 4; k++) begin
            rdReg(3'(k), d);
            check($sformatf("%s.vel%0d", name, k), d, e[k]);
        end
    endtask

    task automatic waitStrobe(input int limit,
                              output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (SampleStrobe) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic vecT mk(
        input logic [15:0] c0, c1, c2, c3,
        input logic [15:0] e0, e1, e2, e3);
        vecT v;
        v.cnt = {c3, c2, c1, c0};
        v.exp = {e3, e2, e1, e0};
        return v;
    endfunction

    initial begin
        logic [15:0] d;
        int   n;
        int   strobes;
        int   first;
        quadT got;

        vecs[0] = mk(16'd100, 16'hFFFE, 16'h0002, 16'h03E8,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000);
        vecs[1] = mk(16'd130, 16'h0003, 16'hFFFC, 16'h03E8,
                     16'h001E, 16'h0005, 16'hFFFA, 16'h0000);
        vecs[2] = mk(16'h0078, 16'h8002, 16'h7FFC, 16'h8000,
                     16'hFFF6, 16'h7FFF, 16'h8000, 16'h7C18);
        vecs[3] = mk(16'h0078, 16'h8002, 16'h7FFC, 16'h0000,
                     16'h0000, 16'h0000, 16'h0000, 16'h8000);

        Reset      = 1'b1;
        bus.Addr   = '0;
        bus.DataWr = '0;
        bus.En     = 1'b1;
        bus.Rd     = 1'b0;
        bus.Wr     = 1'b0;
        setCounts('0);
        step();
        step();
        Reset = 1'b0;

        // Reset state
        check("rst.strobe", {15'd0, SampleStrobe}, 16'd0);
        checkVels("rst", '0);
        rdReg(PERIOD, d);
        check("rst.period", d, 16'd15625);
        rdReg(STATUS, d);
        check("rst.status", d, 16'd0);

        // Table vectors through the scoreboard
        busWrite(PERIOD, 16'd4);
        for (int i = 0; i < 4; i++) begin
            setCounts(vecs[i].cnt);
            expQ.push_back(vecs[i].exp);
            waitStrobe(100, n);
            check($sformatf("v%0d.strobeSeen", i),
                  {15'd0, n > 0}, 16'd1);
            step();
            check($sformatf("v%0d.strobeWidth", i),
                  {15'd0, SampleStrobe}, 16'd0);
            got = expQ.pop_front();
            checkVels($sformatf("v%0d", i), got);
            rdReg(STATUS, d);
            check($sformatf("v%0d.status", i), d, 16'd3);
            clearNew();
            rdReg(STATUS, d);
            check($sformatf("v%0d.statusClr", i), d, 16'd2);
        end

        // Coherence: inputs change right after snapshot
        setCounts({16'h1234, 16'h0000, 16'h8000, 16'h0100});
        expQ.push_back({16'h1234, 16'h8004,
                        16'hFFFE, 16'h0088});
        busWrite(PERIOD, 16'd4);
        repeat (31) step();
        step();
        setCounts({4{16'h5555}});
        step();
        checkVels("coh.calc", vecs[3].exp);
        step();
        step();
        check("coh.noStrobeT4", {15'd0, SampleStrobe}, 16'd0);
        step();
        check("coh.strobeT5", {15'd0, SampleStrobe}, 16'd1);
        step();
        check("coh.strobeT6", {15'd0, SampleStrobe}, 16'd0);
        got = expQ.pop_front();
        checkVels("coh", got);

        // Period 0 stops sampling
        busWrite(PERIOD, 16'd0);
        strobes = 0;
        repeat (1000) begin
            step();
            if (SampleStrobe) strobes++;
        end
        check("period0.strobes", 16'(strobes), 16'd0);
        clearNew();
        rdReg(STATUS, d);
        check("period0.status", d, 16'd2);

        // Period 2 latency, then New set/clear race
        busWrite(PERIOD, 16'd2);
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            if (SampleStrobe) begin
                first = i;
                break;
            end
            step();
        end
        check("period2.latency", 16'(first), 16'd21);
        bus.Addr = STATUS;
        bus.Rd   = 1'b1;
        step();
        bus.Rd   = 1'b0;
        rdReg(STATUS, d);
        check("race.newKept", d, 16'd3);
        checkVels("period2", {16'h4321, 16'h5555,
                              16'hD555, 16'h5455});
        clearNew();
        rdReg(STATUS, d);
        check("race.newCleared", d, 16'd2);
        rdReg(PERIOD, d);
        check("period2.readback", d, 16'd2);

        // Reset at T+2 with a colliding Period write
        busWrite(PERIOD, 16'd2);
        repeat (15) step();
        repeat (2) step();
        Reset      = 1'b1;
        bus.Addr   = PERIOD;
        bus.DataWr = 16'd7;
        bus.Wr     = 1'b1;
        step();
        Reset  = 1'b0;
        bus.Wr = 1'b0;
        strobes = 0;
        repeat (20) begin
            if (SampleStrobe) strobes++;
            step();
        end
        check("midRst.strobes", 16'(strobes), 16'd0);
        checkVels("midRst", '0);
        rdReg(PERIOD, d);
        check("midRst.period", d, 16'd15625);
        rdReg(STATUS, d);
        check("midRst.status", d, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nVec, nMis);
        $finish;
    end

endmodule
